// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed common-anode seven-segment scanner with per-digit enable, dp, leading-zero suppression and PWM brightness
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    localparam int SEL_W = $clog2(NUM_DIGITS),
    localparam int CNT_W = $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [SEL_W-1:0]      sel,
    input  logic [3:0]            num,
    input  logic                  dp_in,
    input  logic                  en_in,
    input  logic                  clear,
    input  logic                  lzs,
    input  logic [3:0]            bright,
    output logic [NUM_DIGITS-1:0] ANODE,
    output logic [6:0]            CATHODE,
    output logic                  DP
);
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [NUM_DIGITS-1:0][3:0] val;
    logic [NUM_DIGITS-1:0]      dp, en, sup;
    logic [CNT_W-1:0]           cnt;
    logic [SEL_W-1:0]           idx;
    logic [63:0]                lhs, rhs;
    logic                       last, vis;

    // digit register file; clear takes priority over a same-cycle write, out-of-range sel is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val <= '0;
            dp  <= '0;
            en  <= '1;
        end else if (clear) begin
            val <= '0;
            dp  <= '0;
            en  <= '1;
        end else if (write && 32'(sel) < NUM_DIGITS) begin
            val[sel] <= num;
            dp[sel]  <= dp_in;
            en[sel]  <= en_in;
        end
    end

    assign last = cnt == CNT_W'(REFRESH_DIV - 1);

    // slot prescaler and scan index; idx advances on the last cycle of each slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            idx <= !last ? idx : idx == SEL_W'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end

    // leading-zero run from the top digit; disabled digits are transparent, digit 0 always shows
    always_comb begin
        logic run;
        run = lzs;
        sup = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            sup[i] = run && en[i] && val[i] == 4'h0;
            run    = run && !(en[i] && val[i] != 4'h0);
        end
    end

    assign lhs = 64'(cnt) << 4;
    assign rhs = (64'(bright) + 64'd1) * 64'(REFRESH_DIV);
    assign vis = lhs < rhs && en[idx] && !sup[idx];

    // registered pin drive: one anode low for a visible digit, everything dark otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ANODE   <= '1;
            CATHODE <= 7'h7F;
            DP      <= 1'b1;
        end else begin
            ANODE   <= vis ? ~(NUM_DIGITS'(1) << idx) : '1;
            CATHODE <= vis ? SEG[val[idx]] : 7'h7F;
            DP      <= ~(vis && dp[idx]);
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: scoreboard bench with a time-based reference model of the scanned display
module tb_sevenseg_scan_ctrl;
    localparam int ND = 6;
    localparam int RD = 5;
    localparam int SW = $clog2(ND);
    localparam logic [13:0] IDLE = {6'h3F, 7'h7F, 1'b1};

    logic clk = 0, reset = 0, write = 0, dp_in = 0, en_in = 1, clear = 0, lzs = 0;
    logic [SW-1:0] sel = '0;
    logic [3:0] num = '0, bright = 4'd15;
    logic [ND-1:0] ANODE;
    logic [6:0] CATHODE;
    logic DP;

    int checks = 0, failures = 0;
    int t = 0;
    logic [13:0] q[$];
    bit [3:0] m_val[ND];
    bit m_dp[ND], m_en[ND];
    logic [6:0] seg[16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset), .write(write), .sel(sel), .num(num),
        .dp_in(dp_in), .en_in(en_in), .clear(clear), .lzs(lzs), .bright(bright),
        .ANODE(ANODE), .CATHODE(CATHODE), .DP(DP)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [13:0] got, logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got anode=%b cath=%b dp=%b, expected anode=%b cath=%b dp=%b",
                     name, $time, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < ND; i++) begin
            m_val[i] = 4'h0;
            m_dp[i]  = 1'b0;
            m_en[i]  = 1'b1;
        end
    endfunction

    // what the pins should show for elapsed cycle t since reset release
    function automatic logic [13:0] expect_out();
        int idx, cnt, hi;
        bit show;
        idx = (t / RD) % ND;
        cnt = t % RD;
        hi = -1;
        for (int i = 0; i < ND; i++) if (m_en[i] && m_val[i] != 0) hi = i;
        show = cnt * 16 < (int'(bright) + 1) * RD && m_en[idx]
               && !(lzs && idx > 0 && idx > hi && m_val[idx] == 0);
        if (!show) return IDLE;
        return {~(6'(1) << idx), seg[m_val[idx]], ~m_dp[idx]};
    endfunction

    // reference model: record the expected pins for this edge, then apply the edge's write/clear
    initial forever begin
        @(posedge clk);
        if (reset) begin
            model_clear();
            t = 0;
            q.push_back(IDLE);
        end else begin
            q.push_back(expect_out());
            if (clear) model_clear();
            else if (write && sel < ND) begin
                m_val[sel] = num;
                m_dp[sel]  = dp_in;
                m_en[sel]  = en_in;
            end
            t++;
        end
    end

    // monitor: pins are presented every cycle, compared mid-cycle
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) check("scan", {ANODE, CATHODE, DP}, q.pop_front());
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int s, int v, bit d = 0, bit e = 1);
        @(negedge clk);
        write = 1; sel = SW'(s); num = 4'(v); dp_in = d; en_in = e;
        @(negedge clk);
        write = 0;
    endtask

    initial begin
        #1 reset = 1;
        #1 check("reset_async", {ANODE, CATHODE, DP}, IDLE);
        tick(2);
        reset = 0;
        for (int i = 0; i < ND; i++) wr(i, i);
        tick(2 * ND * RD);
        wr(3, 3, 0, 0);
        wr(5, 5, 1, 1);
        tick(ND * RD);
        lzs = 1;
        wr(5, 0); wr(4, 0); wr(3, 0); wr(2, 1); wr(1, 2); wr(0, 0);
        tick(ND * RD);
        wr(4, 0, 0, 0); wr(2, 0);
        tick(ND * RD);
        @(negedge clk); clear = 1;
        @(negedge clk); clear = 0;
        tick(ND * RD);
        lzs = 0;
        for (int i = 0; i < ND; i++) wr(i, i + 8, i % 2 == 1);
        bright = 4'd7;
        tick(ND * RD);
        bright = 4'd0;
        tick(ND * RD);
        bright = 4'd15;
        @(negedge clk); clear = 1; write = 1; sel = SW'(2); num = 4'h9;
        @(negedge clk); clear = 0; write = 0;
        tick(ND * RD);
        wr(6, 10); wr(7, 11);
        tick(ND * RD);
        repeat (400) begin
            @(negedge clk);
            write = 1'($urandom_range(0, 1));
            sel   = SW'($urandom_range(0, 7));
            num   = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
            dp_in = 1'($urandom_range(0, 1));
            en_in = $urandom_range(0, 3) != 0;
            clear = $urandom_range(0, 59) == 0;
            if ($urandom_range(0, 19) == 0) lzs = ~lzs;
            if ($urandom_range(0, 24) == 0) bright = 4'($urandom);
        end
        write = 0; clear = 0; lzs = 0; bright = 4'd15;
        for (int i = 0; i < ND; i++) wr(i, 15 - i);
        begin
            int n = 0;
            while (((t / RD) % ND != 5 || t % RD != 2) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                checks++;
                failures++;
                $display("FAIL wait_idx5: scan index 5 not reached within 200 cycles");
            end
        end
        #2 reset = 1; write = 1; sel = SW'(0); num = 4'h5;
        #1 check("reset_mid", {ANODE, CATHODE, DP}, IDLE);
        tick(3);
        reset = 0; write = 0;
        tick(ND * RD + 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Parametrised multiplexed seven-segment display controller: a NUM_DIGITS-entry digit register file written through a sel/num port, scanned onto common-anode displays with a programmable refresh rate. Adds per-digit enable, decimal point, leading-zero suppression and 16-level PWM brightness. Sits between the board-level switch/bus logic and the ANODE/CATHODE/DP pins.

## Interface
- NUM_DIGITS, 8, number of digits (2..16); SEL_W = $clog2(NUM_DIGITS), derived
- REFRESH_DIV, 100000, clock cycles per digit slot (>= 2)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- write  in  1  write strobe, sampled on clk rising edge
- sel  in  SEL_W  target digit index
- num  in  4  hex value to store
- dp_in  in  1  decimal point to store with num
- en_in  in  1  digit enable to store with num (0 = digit blank)
- clear  in  1  synchronous clear of all entries
- lzs  in  1  leading-zero suppression mode
- bright  in  4  brightness level, 0 = 1/16 duty, 15 = full
- ANODE  out  NUM_DIGITS  digit select, active-low, one-hot-low
- CATHODE  out  7  segments {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low

## Operation
- Entry i = {en, dp, val[3:0]}; reset/clear value {1,0,4'h0}.
- Write: write=1 at edge stores {en_in, dp_in, num} into entry[sel]. sel >= NUM_DIGITS ignored. clear=1 has priority over write; both same cycle -> all entries reset values.
- Prescaler cnt counts 0..REFRESH_DIV-1, wraps to 0. At cnt = REFRESH_DIV-1, scan index idx advances; idx = NUM_DIGITS-1 wraps to 0.
- Brightness: slot "on" when cnt*16 < (bright+1)*REFRESH_DIV (products computed at full width, no truncation). bright=15 -> on every cycle.
- Leading-zero suppression (lzs=1): scanning from NUM_DIGITS-1 down, every enabled digit with val=0 is suppressed until the first enabled nonzero digit; disabled digits neither suppress nor stop the run. Digit 0 never suppressed. dp of a suppressed digit also suppressed. lzs evaluated combinationally from current entries.
- Digit visible = on AND en[idx] AND not suppressed. Visible: ANODE bit idx = 0, others 1; CATHODE = decode(val[idx]); DP = ~dp[idx]. Not visible: ANODE all 1, CATHODE 7'h7F, DP 1.
- Decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Never more than one ANODE bit low.

## Timing
- Outputs registered. Reset (async, immediate): ANODE all 1, CATHODE 7'h7F, DP 1, cnt 0, idx 0, entries reset values.
- First edge after reset release: outputs show digit 0 (value 0, "1000000") given bright=15.
- Output latency 1 cycle from cnt/idx/entry state: write at edge N to currently scanned digit -> new CATHODE at edge N+1.
- Each digit occupies exactly REFRESH_DIV cycles; frame = NUM_DIGITS*REFRESH_DIV cycles; idx sequence 0,1,..,NUM_DIGITS-1,0.
- Change of bright/lzs takes effect at next edge; no slot restart.
- Reset mid-slot or mid-write: write lost, scan restarts at idx 0, cnt 0.

## Test plan
- NUM_DIGITS=8, REFRESH_DIV=4, bright=15: reset 10 ns, write digits i=val i (0..7) -> ANODE walks FE,FD,FB,..,7F each 4 cycles, CATHODE matches decode(i), frame 32 cycles.
- Write en_in=0 to digit 3, dp_in=1 to digit 5 -> ANODE FF during slot 3; DP=0 only during slot 5.
- lzs=1, entries 7..0 = 0,0,0,0,0,1,2,0 -> digits 7..3 blank, digits 2,1,0 show 1,2,0; all zero -> only digit 0 shows "1000000".
- bright=7, REFRESH_DIV=16 -> ANODE low 8 of 16 cycles per slot; bright=0 -> 1 of 16.
- clear and write same cycle -> all digits show 0; write with sel=6 when NUM_DIGITS=6 -> no entry changes.
- Assert reset mid-frame at idx=5 -> outputs FF/7F/1 immediately, after release scan resumes at idx 0 with zeros.
